temporal_encoder: RTL and testbench

TEMPORAL_ENCODER -- requirements
Module: temporal_encoder

---
 rtl/temporal_encoder.sv | 112 +++++++++++
 tb/tb_temporal_encoder.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/temporal_encoder.sv
// Temporal N-gram encoder: binds the last N spatial hypervectors with
// position-dependent rotations and presents one registered query per new input.
`ifndef HV_DIMENSION
`define HV_DIMENSION 2000
`endif

module temporal_encoder #(
  parameter int HV_DIMENSION = `HV_DIMENSION,
  parameter int NGRAM_SIZE   = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear,
  input  logic                    hvin_valid,
  output logic                    hvin_ready,
  input  logic [HV_DIMENSION-1:0] hvin,
  output logic                    dout_valid,
  input  logic                    dout_ready,
  output logic [HV_DIMENSION-1:0] dout
);

  // With N=1 there is no history; keep one dummy slot so the array stays legal.
  localparam int HIST_DEPTH = (NGRAM_SIZE > 1) ? NGRAM_SIZE - 1 : 1;
  localparam int CNT_W      = $clog2(NGRAM_SIZE) + 1;
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(NGRAM_SIZE - 1);
  localparam logic [CNT_W-1:0] ONE_COUNT  = CNT_W'(1);

  // Circular right rotate by k positions (k successive 1-bit rotations).
  function automatic logic [HV_DIMENSION-1:0] rotr(input logic [HV_DIMENSION-1:0] x,
                                                   input int k);
    int kk;
    kk = k % HV_DIMENSION;
    if (kk == 0) return x;
    return (x >> kk) | (x << (HV_DIMENSION - kk));
  endfunction

  logic [HV_DIMENSION-1:0] hist_reg [HIST_DEPTH];
  logic [CNT_W-1:0]        fill_reg;
  logic [HV_DIMENSION-1:0] dout_reg;
  logic                    dout_valid_reg;

  logic [HIST_DEPTH-1:0][HV_DIMENSION-1:0] term;
  logic [HV_DIMENSION-1:0] ngram;
  logic                    hvin_fire;
  logic                    dout_fire;
  logic                    history_full;
  logic                    produce;

  assign hvin_ready   = ~dout_valid_reg | dout_ready;
  assign hvin_fire    = hvin_valid & hvin_ready;
  assign dout_fire    = dout_valid_reg & dout_ready;
  assign history_full = (fill_reg == FULL_COUNT);
  // A clear coincident with an input restarts the window, so only N=1 may still emit.
  assign produce      = hvin_fire & history_full & (~clear | (NGRAM_SIZE == 1));

  assign dout_valid = dout_valid_reg;
  assign dout       = dout_reg;

  genvar gi;
  generate
    for (gi = 0; gi < HIST_DEPTH; gi++) begin : g_term
      assign term[gi] = rotr(hist_reg[gi], gi + 1);
    end
  endgenerate

  always_comb begin
    ngram = hvin;
    if (NGRAM_SIZE > 1) begin
      for (int k = 0; k < HIST_DEPTH; k++) begin
        ngram = ngram ^ term[k];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dout_valid_reg <= 1'b0;
      dout_reg       <= '0;
      fill_reg       <= '0;
      for (int k = 0; k < HIST_DEPTH; k++) begin
        hist_reg[k] <= '0;
      end
    end else begin
      if (produce) begin
        dout_reg       <= ngram;
        dout_valid_reg <= 1'b1;
      end else if (dout_fire) begin
        dout_valid_reg <= 1'b0;
      end

      if (hvin_fire) begin
        if (NGRAM_SIZE > 1) begin
          hist_reg[0] <= hvin;
          for (int k = 1; k < HIST_DEPTH; k++) begin
            hist_reg[k] <= clear ? '0 : hist_reg[k-1];
          end
        end
        if (clear) begin
          fill_reg <= (NGRAM_SIZE > 1) ? ONE_COUNT : '0;
        end else if (!history_full) begin
          fill_reg <= fill_reg + ONE_COUNT;
        end
      end else if (clear) begin
        fill_reg <= '0;
        for (int k = 0; k < HIST_DEPTH; k++) begin
          hist_reg[k] <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_temporal_encoder.sv
// Scoreboard bench for temporal_encoder: D=8 with N=3 and N=1 instances,
// directed vectors with hand-computed N-gram results.
module tb_temporal_encoder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clear = 1'b0;
  logic       hvin_valid = 1'b0;
  logic       hvin_ready;
  logic [7:0] hvin = 8'h00;
  logic       dout_valid;
  logic       dout_ready = 1'b1;
  logic [7:0] dout;

  logic       n1_clear = 1'b0;
  logic       n1_hvin_valid = 1'b0;
  logic       n1_hvin_ready;
  logic [7:0] n1_hvin = 8'h00;
  logic       n1_dout_valid;
  logic       n1_dout_ready = 1'b1;
  logic [7:0] n1_dout;

  int checks = 0;
  int failures = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp1_q[$];

  always #5 clk = ~clk;

  temporal_encoder #(.HV_DIMENSION(8), .NGRAM_SIZE(3)) dut (
    .clk(clk), .rst(rst), .clear(clear),
    .hvin_valid(hvin_valid), .hvin_ready(hvin_ready), .hvin(hvin),
    .dout_valid(dout_valid), .dout_ready(dout_ready), .dout(dout)
  );

  temporal_encoder #(.HV_DIMENSION(8), .NGRAM_SIZE(1)) dut_n1 (
    .clk(clk), .rst(rst), .clear(n1_clear),
    .hvin_valid(n1_hvin_valid), .hvin_ready(n1_hvin_ready), .hvin(n1_hvin),
    .dout_valid(n1_dout_valid), .dout_ready(n1_dout_ready), .dout(n1_dout)
  );

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%02h expected 0x%02h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%02h", name, act);
    end
  endtask

  // Monitors: every accepted output is matched against the next expectation.
  always @(negedge clk) begin
    if (!rst && dout_valid && dout_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL n3_unexpected_out: got 0x%02h expected none", dout);
      end else begin
        check("n3_dout", dout, exp_q.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && n1_dout_valid && n1_dout_ready) begin
      if (exp1_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL n1_unexpected_out: got 0x%02h expected none", n1_dout);
      end else begin
        check("n1_dout", n1_dout, exp1_q.pop_front());
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Present one input (optionally with clear) and hold it until accepted.
  task automatic send(input bit n1, input logic [7:0] v, input bit clr,
                      input bit has_exp, input logic [7:0] e);
    int waited;
    bit rdy;
    waited = 0;
    if (n1) begin
      n1_hvin = v; n1_hvin_valid = 1'b1; n1_clear = clr;
      if (has_exp) exp1_q.push_back(e);
    end else begin
      hvin = v; hvin_valid = 1'b1; clear = clr;
      if (has_exp) exp_q.push_back(e);
    end
    forever begin
      @(negedge clk);
      rdy = n1 ? n1_hvin_ready : hvin_ready;
      if (rdy) break;
      waited++;
      if (waited > 20) begin
        checks++;
        failures++;
        $display("FAIL send_timeout: got ready=0 expected ready=1 within 20 cycles");
        break;
      end
    end
    @(posedge clk);
    #1;
    hvin_valid = 1'b0; clear = 1'b0;
    n1_hvin_valid = 1'b0; n1_clear = 1'b0;
  endtask

  initial begin
    idle(2);
    check("rst_dout_valid", {7'd0, dout_valid}, 8'h00);
    check("rst_dout", dout, 8'h00);
    check("rst_hvin_ready", {7'd0, hvin_ready}, 8'h01);
    check("rst_n1_dout_valid", {7'd0, n1_dout_valid}, 8'h00);
    rst = 1'b0;

    // Fill, then sliding window.
    send(0, 8'h01, 0, 0, 8'h00);
    send(0, 8'h02, 0, 0, 8'h00);
    send(0, 8'h04, 0, 1, 8'h45);
    send(0, 8'h00, 0, 1, 8'h82);
    send(0, 8'h10, 0, 1, 8'h11);
    idle(1);

    // Backpressure: output 0x28 stalls while 0x40 waits.
    dout_ready = 1'b0;
    send(0, 8'h20, 0, 1, 8'h28);
    hvin = 8'h40; hvin_valid = 1'b1;
    exp_q.push_back(8'h54);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_hvin_ready", {7'd0, hvin_ready}, 8'h00);
      check("bp_dout_valid", {7'd0, dout_valid}, 8'h01);
      check("bp_dout_stable", dout, 8'h28);
    end
    @(posedge clk); #1;
    dout_ready = 1'b1;
    @(negedge clk);
    check("bp_release_ready", {7'd0, hvin_ready}, 8'h01);
    @(posedge clk); #1;
    hvin_valid = 1'b0;
    idle(1);

    // Clear alone, then three fresh inputs.
    clear = 1'b1;
    idle(1);
    clear = 1'b0;
    send(0, 8'h03, 0, 0, 8'h00);
    send(0, 8'h05, 0, 0, 8'h00);
    send(0, 8'h09, 0, 1, 8'h4B);
    idle(1);

    // Clear coincident with an accepted input: it becomes the first sample.
    send(0, 8'h06, 1, 0, 8'h00);
    send(0, 8'h0C, 0, 0, 8'h00);
    send(0, 8'h18, 0, 1, 8'h9F);
    idle(1);

    // Reset mid-stream with a pending output and full history.
    dout_ready = 1'b0;
    send(0, 8'h33, 0, 0, 8'h00);
    @(negedge clk);
    check("pre_rst_dout_valid", {7'd0, dout_valid}, 8'h01);
    check("pre_rst_dout", dout, 8'h3C);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_dout_valid", {7'd0, dout_valid}, 8'h00);
    check("mid_rst_dout", dout, 8'h00);
    @(posedge clk); #1;
    dout_ready = 1'b1;
    send(0, 8'h01, 0, 0, 8'h00);
    send(0, 8'h02, 0, 0, 8'h00);
    send(0, 8'h04, 0, 1, 8'h45);
    idle(2);

    // N=1: every input is its own output; clear is invisible.
    send(1, 8'h5A, 0, 1, 8'h5A);
    send(1, 8'hA5, 1, 1, 8'hA5);
    n1_clear = 1'b1;
    idle(1);
    n1_clear = 1'b0;
    send(1, 8'h3C, 0, 1, 8'h3C);
    idle(3);

    check("n3_pending_left", 8'(exp_q.size()), 8'h00);
    check("n1_pending_left", 8'(exp1_q.size()), 8'h00);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
